// File: rtl/dds_pwm_pkg.sv
// Shared types and helpers for the DDS-to-PWM output stage: dead-time FSM
// state encoding, midscale constant and the sample-to-duty conversion.
package dds_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DEAD = 2'd3
  } pwm_state_t;

  localparam logic [15:0] MIDSCALE = 16'h8000;

  // Offset-binary conversion of a signed sample followed by truncation to the
  // PWM resolution; the caller narrows the result to its counter width.
  function automatic logic [31:0] to_duty(input logic [31:0] sample,
                                          input int data_w,
                                          input int cnt_w);
    logic [31:0] flipped;
    flipped = sample ^ (32'd1 << (data_w - 32'sd1));
    return flipped >> (data_w - cnt_w);
  endfunction

endpackage

// File: rtl/pwm_dead_time_gen.sv
// Complementary half-bridge drive with guaranteed low-low dead time on every
// hi<->lo swap; pulses shorter than the dead time are swallowed.
module pwm_dead_time_gen
  import dds_pwm_pkg::*;
#(
  parameter int DEAD_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYC);

  pwm_state_t state_r, state_s;
  logic [3:0] dead_r, dead_s;

  // Next-state logic: the exit decision from DEAD samples raw on the last dead cycle.
  always_comb begin
    state_s = state_r;
    dead_s  = dead_r;
    if (!enable) begin
      state_s = ST_IDLE;
      dead_s  = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_DEAD;
          dead_s  = DEAD_LOAD;
        end
        ST_HI: begin
          if (!raw) begin
            state_s = ST_DEAD;
            dead_s  = DEAD_LOAD;
          end else begin
            state_s = ST_HI;
          end
        end
        ST_LO: begin
          if (raw) begin
            state_s = ST_DEAD;
            dead_s  = DEAD_LOAD;
          end else begin
            state_s = ST_LO;
          end
        end
        ST_DEAD: begin
          if (dead_r <= 4'd1) begin
            dead_s  = 4'd0;
            state_s = raw ? ST_HI : ST_LO;
          end else begin
            dead_s  = dead_r - 4'd1;
            state_s = ST_DEAD;
          end
        end
        default: begin
          state_s = ST_IDLE;
          dead_s  = 4'd0;
        end
      endcase
    end
  end

  // State, dead counter and registered drive outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      dead_r  <= 4'd0;
      pwm_hi  <= 1'b0;
      pwm_lo  <= 1'b0;
    end else begin
      state_r <= state_s;
      dead_r  <= dead_s;
      pwm_hi  <= (state_s == ST_HI);
      pwm_lo  <= (state_s == ST_LO);
    end
  end

endmodule

// File: rtl/dds_pwm_modulator.sv
// Converts signed DDS samples into a dead-time protected complementary PWM pair;
// samples are double-buffered and only take effect at period boundaries.
module dds_pwm_modulator
  import dds_pwm_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 10,
  parameter int DEAD_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ack,
  output logic              period_start,
  output logic              pwm_hi,
  output logic              pwm_lo
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HALF     = {1'b1, {(CNT_W-1){1'b0}}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] shadow_r;
  logic [CNT_W-1:0] duty_act_r;
  logic [CNT_W-1:0] conv_s;
  logic             wrap_s;
  logic             raw_r;

  assign conv_s = CNT_W'(to_duty(32'(sample_in), DATA_W, CNT_W));
  assign wrap_s = enable && (cnt_r == CNT_MAX);

  // Free-running period counter, parked at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (!enable) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Shadow/active duty; a strobe on the wrap cycle bypasses the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r   <= HALF;
      duty_act_r <= HALF;
    end else begin
      if (sample_valid) begin
        shadow_r <= conv_s;
      end
      if (wrap_s) begin
        duty_act_r <= sample_valid ? conv_s : shadow_r;
      end
    end
  end

  // Handshake pulses land on the cnt==0 cycle; raw compare is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_ack   <= 1'b0;
      period_start <= 1'b0;
      raw_r        <= 1'b0;
    end else begin
      sample_ack   <= wrap_s;
      period_start <= wrap_s;
      raw_r        <= enable && (cnt_r < duty_act_r);
    end
  end

  pwm_dead_time_gen #(
    .DEAD_CYC(DEAD_CYC)
  ) u_dead_time (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .raw    (raw_r),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

endmodule

// File: tb/tb_dds_pwm_modulator.sv
// Self-checking bench for dds_pwm_modulator: per-cycle reference model,
// table of per-period duty vectors, and hand-written corner sequences.
module tb_dds_pwm_modulator;

  localparam int DEAD_CYC = 4;
  localparam int PERIOD   = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ack;
  logic        period_start;
  logic        pwm_hi;
  logic        pwm_lo;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  dds_pwm_modulator #(.DATA_W(16), .CNT_W(10), .DEAD_CYC(DEAD_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ack   (sample_ack),
    .period_start (period_start),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  localparam int M_OFF = 0, M_DEAD = 1, M_HI = 2, M_LO = 3;
  int m_cnt = 0, m_duty = 512, m_shadow = 512, m_mode = M_OFF, m_rem = 0;
  bit m_raw = 0, m_hi = 0, m_lo = 0, m_ack = 0, m_ps = 0;

  function automatic int conv(input logic [15:0] s);
    return (int'($signed(s)) + 32768) / 64;
  endfunction

  always @(posedge clk or posedge reset) begin : ref_model
    int c;
    if (reset) begin
      m_cnt = 0; m_duty = 512; m_shadow = 512; m_mode = M_OFF; m_rem = 0;
      m_raw = 0; m_hi = 0; m_lo = 0; m_ack = 0; m_ps = 0;
    end else begin
      c = conv(sample_in);
      if (!enable) m_mode = M_OFF;
      else begin
        case (m_mode)
          M_OFF:  begin m_mode = M_DEAD; m_rem = DEAD_CYC; end
          M_HI:   if (!m_raw) begin m_mode = M_DEAD; m_rem = DEAD_CYC; end
          M_LO:   if (m_raw)  begin m_mode = M_DEAD; m_rem = DEAD_CYC; end
          default: begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_mode = m_raw ? M_HI : M_LO;
          end
        endcase
      end
      m_hi  = (m_mode == M_HI);
      m_lo  = (m_mode == M_LO);
      m_ack = enable && (m_cnt == PERIOD - 1);
      m_ps  = m_ack;
      m_raw = enable && (m_cnt < m_duty);
      if (enable && m_cnt == PERIOD - 1) m_duty = sample_valid ? c : m_shadow;
      if (sample_valid) m_shadow = c;
      m_cnt = enable ? (m_cnt + 1) % PERIOD : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_outputs{hi,lo,ack,ps}", int'({pwm_hi, pwm_lo, sample_ack, period_start}),
            int'({m_hi, m_lo, m_ack, m_ps}));
      check("hi_lo_overlap", int'(pwm_hi & pwm_lo), 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_ack && n < 3000);
    check("ack_within_bound", int'(sample_ack), 1);
  endtask

  task automatic count_period(output int hi, output int lo);
    hi = 0; lo = 0;
    for (int i = 0; i < PERIOD; i++) begin
      hi += int'(pwm_hi);
      lo += int'(pwm_lo);
      @(negedge clk);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    @(posedge clk); #1;
    sample_in = v; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] smp;
    int          hi;
    int          lo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, n2, hi, lo, off_cnt, acks;
    vecs[0] = '{16'h8000,    0, 1024};
    vecs[1] = '{16'h0000,  508,  508};
    vecs[2] = '{16'h4000,  764,  252};
    vecs[3] = '{16'h7FFF, 1020,    0};
    vecs[4] = '{16'hC000,  252,  764};
    vecs[5] = '{16'h8080,    0, 1020};
    vecs[6] = '{16'h8140,    1, 1015};
    vecs[7] = '{16'h003F,  508,  508};
    vecs[8] = '{16'hFFFF,  507,  509};

    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_in = 16'h0000;
    #52;
    check("reset_pwm_hi", int'(pwm_hi), 0);
    check("reset_pwm_lo", int'(pwm_lo), 0);
    check("reset_sample_ack", int'(sample_ack), 0);
    check("reset_period_start", int'(period_start), 0);
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b1; chk_en = 1'b1;

    // Default midscale duty: period length and per-period drive counts
    wait_ack(n);
    wait_ack(n);
    check("ack_period", n, PERIOD);
    count_period(hi, lo);
    check("midscale_hi_cycles", hi, 508);
    check("midscale_lo_cycles", lo, 508);

    // Table: strobe mid-period, let it transfer, measure the following steady period
    for (int i = 0; i < 9; i++) begin
      strobe(vecs[i].smp);
      wait_ack(n);
      wait_ack(n);
      count_period(hi, lo);
      check($sformatf("vec%0d_hi_cycles", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo_cycles", i), lo, vecs[i].lo);
    end

    // Strobe on the wrap cycle is forwarded into the very next period
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (m_cnt != PERIOD - 1 && n < 1100);
    sample_in = 16'h4000; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    wait_ack(n);
    count_period(hi, lo);
    check("fwd_hi_cycles", hi, 764);
    check("fwd_lo_cycles", lo, 252);

    // Asynchronous reset while high side is driving
    repeat (100) @(negedge clk);
    check("pre_reset_in_hi", int'(pwm_hi), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_hi_low", int'(pwm_hi), 0);
    check("async_reset_lo_low", int'(pwm_lo), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pwm_hi && n < 50);
    check("restart_first_hi_negedge", n, 6);
    wait_ack(n2);
    check("restart_first_ack", n + n2, PERIOD + 1);

    // Enable dropped while low side is driving
    repeat (700) @(negedge clk);
    check("pre_disable_in_lo", int'(pwm_lo), 1);
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("disable_hi_low", int'(pwm_hi), 0);
    check("disable_lo_low", int'(pwm_lo), 0);
    acks = 0;
    repeat (1100) begin
      @(negedge clk);
      acks += int'(sample_ack | period_start);
    end
    check("no_pulses_while_disabled", acks, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_ack(n);
    check("reenable_first_ack", n, PERIOD + 1);

    // Randomized strobes, wrap-cycle strobes and enable drops against the model
    off_cnt = 0;
    for (int i = 0; i < 20 * PERIOD; i++) begin
      @(posedge clk); #1;
      sample_in    = 16'($urandom);
      sample_valid = ($urandom_range(0, 99) == 0) ||
                     (m_cnt == PERIOD - 1 && $urandom_range(0, 1) == 1);
      if (off_cnt > 0) begin
        off_cnt--;
        enable = (off_cnt == 0);
      end else if ($urandom_range(0, 2999) == 0) begin
        off_cnt = $urandom_range(1, 40);
        enable  = 1'b0;
      end
    end
    enable = 1'b1;
    sample_valid = 1'b0;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
